// File: rtl/mmcm_drp_pkg.sv
// Shared types, reconfiguration tables and FSM encoding for the MMCM DRP reconfigurator.
package mmcm_drp_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int IDX_W       = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [3:0] {
        IDLE, ASSERT_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, WAIT_LOCK, FINISH
    } state_e;

    // mask bits select the bits kept from the current register contents
    localparam drp_entry_t TABLE_A [NUM_ENTRIES] = '{
        '{7'h08, 16'h1000, 16'h0145},
        '{7'h09, 16'hFC00, 16'h0000},
        '{7'h0A, 16'h1000, 16'h0083},
        '{7'h0B, 16'hFC00, 16'h0080},
        '{7'h14, 16'h1000, 16'h1208},
        '{7'h15, 16'h8000, 16'h0000},
        '{7'h18, 16'hFC00, 16'h03E8},
        '{7'h4E, 16'h66FF, 16'h0800}
    };

    localparam drp_entry_t TABLE_B [NUM_ENTRIES] = '{
        '{7'h08, 16'h1000, 16'h1082},
        '{7'h09, 16'hFC00, 16'h0080},
        '{7'h0A, 16'h1000, 16'h0104},
        '{7'h0B, 16'hFC00, 16'h0000},
        '{7'h14, 16'h1000, 16'h1410},
        '{7'h15, 16'h8000, 16'hC400},
        '{7'h18, 16'hFC00, 16'hFFFF},
        '{7'h4F, 16'h0000, 16'h9100}
    };

    function automatic drp_entry_t rom_lookup(input logic [IDX_W:0] key);
        return key[IDX_W] ? TABLE_B[key[IDX_W-1:0]] : TABLE_A[key[IDX_W-1:0]];
    endfunction

endpackage

// File: rtl/mmcm_drp_lock_sync.sv
// Two-flop synchronizer bringing MMCM LOCKED into the DCLK domain.
module mmcm_drp_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[0], async_i};
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCM reconfiguration via DRP read-modify-write of a selectable 8-entry table.
// Define MMCM_DRP_TIMEOUT_EN to bound the DRDY/LOCKED waits and enable ERROR.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SEL,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic        MMCM_RST,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    output logic        DEN,
    output logic        DWE,
    input  logic [15:0] DO,
    input  logic        DRDY,
    input  logic        LOCKED
);

`ifdef MMCM_DRP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_HOLD_CYCLES) ? TIMEOUT_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        daddr_q, daddr_d;
    logic [15:0]       di_q, di_d;
    logic              err_q, err_d;
    logic              locked_s;
    logic              tmo;
    drp_entry_t        ent_cur, ent_nxt;

    mmcm_drp_lock_sync u_lock_sync (
        .clk_i   (DCLK),
        .rst_i   (RST),
        .async_i (LOCKED),
        .sync_o  (locked_s)
    );

    assign ent_cur = rom_lookup({sel_q, idx_q});
    assign ent_nxt = rom_lookup({sel_d, idx_d});
    assign tmo     = TMO_EN && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            daddr_q <= '0;
            di_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (START) begin
                state_d = ASSERT_RST;
                sel_d   = SEL;
                idx_d   = '0;
                err_d   = 1'b0;
            end
            ASSERT_RST: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) state_d = RD_REQ;
                else                                      cnt_d   = cnt_q + 1'b1;
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (DRDY) begin
                    di_d    = (DO & ent_cur.mask) | (ent_cur.data & ~ent_cur.mask);
                    state_d = WR_REQ;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: begin
                if (DRDY) begin
                    state_d = NEXT;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = WAIT_LOCK;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD_REQ;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = FINISH;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // address is registered on entry to the read so it holds through the write and beyond
        if (state_d == RD_REQ) daddr_d = ent_nxt.addr;
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        BUSY     = 1'b0;
        DONE     = 1'b0;
        MMCM_RST = 1'b0;
        DEN      = 1'b0;
        DWE      = 1'b0;
        case (state_q)
            ASSERT_RST, RD_WAIT, WR_WAIT, NEXT: begin
                BUSY     = 1'b1;
                MMCM_RST = 1'b1;
            end
            RD_REQ: begin
                BUSY     = 1'b1;
                MMCM_RST = 1'b1;
                DEN      = 1'b1;
            end
            WR_REQ: begin
                BUSY     = 1'b1;
                MMCM_RST = 1'b1;
                DEN      = 1'b1;
                DWE      = 1'b1;
            end
            WAIT_LOCK: BUSY = 1'b1;
            FINISH:    DONE = 1'b1;
            default: ;
        endcase
    end

    assign DADDR = daddr_q;
    assign DI    = di_q;
    assign ERROR = err_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a 3-cycle-latency DRP model and a LOCKED model.
module tb_mmcm_drp_reconfig;

    logic        DCLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SEL = 1'b0;
    logic        BUSY, DONE, ERROR, MMCM_RST, DEN, DWE;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO = 16'h0000;
    logic        DRDY = 1'b0;
    logic        LOCKED = 1'b0;

    mmcm_drp_reconfig dut (
        .DCLK(DCLK), .RST(RST), .START(START), .SEL(SEL),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .MMCM_RST(MMCM_RST),
        .DADDR(DADDR), .DI(DI), .DEN(DEN), .DWE(DWE),
        .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED)
    );

    always #5 DCLK = ~DCLK;

    int total = 0;
    int bad = 0;

    // model state, written only by the model process
    int          cyc = 0;
    int          n_tr = 0;
    logic        tr_we   [512];
    logic [6:0]  tr_addr [512];
    logic [15:0] tr_di   [512];
    int          tr_cyc  [512];
    int          done_cnt = 0;
    int          mrst_hi = 0;
    int          mrst_rise = 0;
    int          proto_err = 0;
    logic        mrst_prev = 1'b0;
    logic [3:0]  pipe = '0;
    int          lk = 0;

    // stimulus state, written only by the initial block
    bit          drp_en = 1'b1;
    logic [15:0] do_val = 16'hFFFF;
    int          b_tr, b_done, b_mhi, b_mrise, b_perr;
    int          start_cyc, done_cyc;

    logic [6:0]  ea  [8] = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15, 7'h18, 7'h4E};
    logic [15:0] eda [8] = '{16'h1145, 16'hFC00, 16'h1083, 16'hFC80, 16'h1208, 16'h8000, 16'hFFE8, 16'h6EFF};
    logic [6:0]  eb  [8] = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15, 7'h18, 7'h4F};
    logic [15:0] edb [8] = '{16'h0082, 16'h0080, 16'h0104, 16'h0000, 16'h0410, 16'h4400, 16'h03FF, 16'h9100};

    // DRP slave: DRDY one cycle, three cycles after the DEN cycle; LOCKED 20 cycles after MMCM_RST falls
    always @(negedge DCLK) begin
        cyc = cyc + 1;
        DO  = do_val;
        if (RST) begin
            pipe = '0;
        end else begin
            if (DEN && pipe[2:0] != 3'b000) proto_err = proto_err + 1;
            if (DWE && !DEN) proto_err = proto_err + 1;
            if (DEN) begin
                if (n_tr < 512) begin
                    tr_we[n_tr] = DWE; tr_addr[n_tr] = DADDR; tr_di[n_tr] = DI; tr_cyc[n_tr] = cyc;
                end
                n_tr = n_tr + 1;
            end
            pipe = {pipe[2:0], DEN && drp_en};
        end
        DRDY = pipe[3];
        if (DONE) done_cnt = done_cnt + 1;
        if (MMCM_RST) mrst_hi = mrst_hi + 1;
        if (MMCM_RST && !mrst_prev) mrst_rise = mrst_rise + 1;
        mrst_prev = MMCM_RST;
        if (MMCM_RST) lk = 0;
        else if (lk < 20) lk = lk + 1;
        LOCKED = (lk >= 20);
    end

    task automatic start_op(input logic s);
        @(posedge DCLK); #1;
        b_tr = n_tr; b_done = done_cnt; b_mhi = mrst_hi; b_mrise = mrst_rise; b_perr = proto_err;
        SEL = s; START = 1'b1; start_cyc = cyc + 1;
        @(posedge DCLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge DCLK); #1;
            if (DONE === 1'b1) begin ok = 1'b1; done_cyc = cyc + 1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge DCLK); #1;
        total++;
        if ({BUSY, DONE, ERROR, MMCM_RST, DEN, DWE, DADDR, DI} !== 29'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {BUSY, DONE, ERROR, MMCM_RST, DEN, DWE, DADDR, DI});
        end
        RST = 1'b0;
        repeat (5) @(posedge DCLK); #1;
        total++;
        if (BUSY !== 1'b0 || n_tr != 0) begin
            bad++; $display("FAIL idle_quiet busy=%b trans=%0d want busy=0 trans=0", BUSY, n_tr);
        end
    endtask

    task automatic test_table_a;
        bit ok;
        logic [31:0] got, exp;
        do_val = 16'hFFFF;
        start_op(1'b0);
        wait_done(500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tblA_done_timeout got=no_done want=done"); end
        repeat (3) @(posedge DCLK); #1;
        total++;
        if (n_tr - b_tr != 16) begin bad++; $display("FAIL tblA_count got=%0d want=16", n_tr - b_tr); end
        for (int e = 0; e < 8; e++) begin
            got = {tr_we[b_tr+2*e], tr_addr[b_tr+2*e], tr_we[b_tr+2*e+1], tr_addr[b_tr+2*e+1], tr_di[b_tr+2*e+1]};
            exp = {1'b0, ea[e], 1'b1, ea[e], eda[e]};
            total++;
            if (got !== exp) begin bad++; $display("FAIL tblA_entry%0d got=%h want=%h", e, got, exp); end
        end
        total++;
        if (tr_cyc[b_tr] - start_cyc != 5) begin
            bad++; $display("FAIL first_den_delay got=%0d want=5", tr_cyc[b_tr] - start_cyc);
        end
        total++;
        if (mrst_hi - b_mhi != 76 || mrst_rise - b_mrise != 1) begin
            bad++; $display("FAIL mmcm_rst_window got=%0d/%0d want=76/1", mrst_hi - b_mhi, mrst_rise - b_mrise);
        end
        total++;
        if (done_cnt - b_done != 1 || ERROR !== 1'b0 || BUSY !== 1'b0) begin
            bad++; $display("FAIL tblA_finish done=%0d err=%b busy=%b want 1/0/0", done_cnt - b_done, ERROR, BUSY);
        end
        total++;
        if (proto_err != b_perr) begin bad++; $display("FAIL drp_protocol got=%0d want=0", proto_err - b_perr); end
    endtask

    task automatic test_table_b;
        bit ok;
        logic [31:0] got, exp;
        do_val = 16'h0000;
        start_op(1'b1);
        wait_done(500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tblB_done_timeout got=no_done want=done"); end
        total++;
        if (n_tr - b_tr != 16) begin bad++; $display("FAIL tblB_count got=%0d want=16", n_tr - b_tr); end
        for (int e = 0; e < 8; e++) begin
            got = {tr_we[b_tr+2*e], tr_addr[b_tr+2*e], tr_we[b_tr+2*e+1], tr_addr[b_tr+2*e+1], tr_di[b_tr+2*e+1]};
            exp = {1'b0, eb[e], 1'b1, eb[e], edb[e]};
            total++;
            if (got !== exp) begin bad++; $display("FAIL tblB_entry%0d got=%h want=%h", e, got, exp); end
        end
        do_val = 16'hFFFF;
    endtask

    task automatic test_restart_ignored;
        bit ok;
        bit seen;
        seen = 1'b0;
        start_op(1'b0);
        for (int i = 0; i < 300; i++) begin
            @(posedge DCLK); #1;
            if (n_tr - b_tr >= 8) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL restart_reach_wr4 got=%0d want>=8", n_tr - b_tr); end
        SEL = 1'b1; START = 1'b1;
        @(posedge DCLK); #1;
        START = 1'b0; SEL = 1'b0;
        wait_done(500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL restart_done_timeout got=no_done want=done"); end
        repeat (6) @(posedge DCLK); #1;
        total++;
        if (n_tr - b_tr != 16 || tr_di[b_tr+15] !== eda[7]) begin
            bad++; $display("FAIL restart_trans got=%0d/%h want=16/%h", n_tr - b_tr, tr_di[b_tr+15], eda[7]);
        end
        total++;
        if (done_cnt - b_done != 1 || BUSY !== 1'b0) begin
            bad++; $display("FAIL restart_single_done got=%0d busy=%b want=1 busy=0", done_cnt - b_done, BUSY);
        end
    endtask

    task automatic test_start_held;
        bit ok;
        @(posedge DCLK); #1;
        SEL = 1'b0; START = 1'b1;
        wait_done(500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL held_done_timeout got=no_done want=done"); end
        @(posedge DCLK); #1;
        total++;
        if (BUSY !== 1'b0) begin bad++; $display("FAIL held_idle_gap busy=%b want=0", BUSY); end
        @(posedge DCLK); #1;
        total++;
        if (BUSY !== 1'b1 || MMCM_RST !== 1'b1) begin
            bad++; $display("FAIL held_retrigger busy=%b mrst=%b want=1/1", BUSY, MMCM_RST);
        end
        START = 1'b0;
        wait_done(500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL held_second_done got=no_done want=done"); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        seen = 1'b0;
        start_op(1'b0);
        for (int i = 0; i < 300; i++) begin
            @(posedge DCLK); #1;
            if (n_tr - b_tr >= 6) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen || DADDR !== 7'h0A || DI !== 16'h1083) begin
            bad++; $display("FAIL midrst_setup got=%0d/%h/%h want>=6/0a/1083", n_tr - b_tr, DADDR, DI);
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if ({BUSY, DONE, ERROR, MMCM_RST, DEN, DWE, DADDR, DI} !== 29'd0) begin
            bad++; $display("FAIL midrst_outputs got=%h want=0", {BUSY, DONE, ERROR, MMCM_RST, DEN, DWE, DADDR, DI});
        end
        repeat (3) @(posedge DCLK); #1;
        RST = 1'b0;
        start_op(1'b0);
        wait_done(500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_redo_timeout got=no_done want=done"); end
        total++;
        if (n_tr - b_tr != 16 || tr_addr[b_tr] !== 7'h08 || tr_we[b_tr] !== 1'b0 || tr_di[b_tr+1] !== eda[0]) begin
            bad++; $display("FAIL midrst_redo got=%0d/%h/%h want=16/08/%h", n_tr - b_tr, tr_addr[b_tr], tr_di[b_tr+1], eda[0]);
        end
    endtask

    task automatic test_no_drdy;
        bit ok;
        drp_en = 1'b0;
        start_op(1'b0);
`ifdef MMCM_DRP_TIMEOUT_EN
        wait_done(1500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tmo_done_timeout got=no_done want=done"); end
        total++;
        if (done_cyc - tr_cyc[b_tr] != 1025) begin
            bad++; $display("FAIL tmo_latency got=%0d want=1025", done_cyc - tr_cyc[b_tr]);
        end
        total++;
        if (ERROR !== 1'b1 || MMCM_RST !== 1'b0 || n_tr - b_tr != 1) begin
            bad++; $display("FAIL tmo_state err=%b mrst=%b trans=%0d want 1/0/1", ERROR, MMCM_RST, n_tr - b_tr);
        end
        @(posedge DCLK); #1;
        total++;
        if (ERROR !== 1'b1 || BUSY !== 1'b0) begin
            bad++; $display("FAIL tmo_sticky err=%b busy=%b want 1/0", ERROR, BUSY);
        end
        drp_en = 1'b1;
        start_op(1'b0);
        total++;
        if (ERROR !== 1'b0 || BUSY !== 1'b1) begin
            bad++; $display("FAIL tmo_clear err=%b busy=%b want 0/1", ERROR, BUSY);
        end
        wait_done(500, ok);
        total++;
        if (!ok || ERROR !== 1'b0) begin bad++; $display("FAIL tmo_recover ok=%b err=%b want 1/0", ok, ERROR); end
`else
        repeat (1200) @(posedge DCLK); #1;
        total++;
        if (BUSY !== 1'b1 || ERROR !== 1'b0 || done_cnt != b_done || n_tr - b_tr != 1) begin
            bad++; $display("FAIL unbounded_wait busy=%b err=%b done=%0d trans=%0d want 1/0/0/1",
                            BUSY, ERROR, done_cnt - b_done, n_tr - b_tr);
        end
        ok = 1'b1;
        RST = 1'b1;
        repeat (2) @(posedge DCLK); #1;
        RST = 1'b0;
        drp_en = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_table_a();
        test_table_b();
        test_restart_ignored();
        test_start_held();
        test_reset_mid();
        test_no_drdy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
